// File: rtl/ysyx_25030093_bus_arbiter.sv
// Merges the core's IFU and LSU request ports onto one memory port, one transaction in flight.
// Optional wait timeout with error response: define YSYX_ARB_TIMEOUT_EN.
module ysyx_25030093_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LSU_PRIO       = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [1:0]          lsu_size,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  output logic                mem_reqValid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [1:0]          mem_size,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_gnt;
  logic                r_last_lsu;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [1:0]          r_mem_size;
  logic                r_mem_wen;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W/8-1:0] r_mem_wmask;

  logic w_any_req;
  logic w_pick_lsu;
  logic w_resp;
  logic w_timeout;
  logic w_done;

`ifdef YSYX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Counter idles at zero outside WAIT, so it is clear on every WAIT entry.
  always_ff @(posedge clock) begin
    if (reset || r_state != S_WAIT) r_cnt <= '0;
    else                            r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_WAIT) && !mem_respValid &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_any_req     = ifu_reqValid || lsu_reqValid;
    // On a tie: fixed LSU priority, or LSU only if IFU owned the last transaction.
    w_pick_lsu    = lsu_reqValid && (!ifu_reqValid || (LSU_PRIO != 0) || !r_last_lsu);
    w_resp        = (r_state == S_WAIT) && mem_respValid;
    w_done        = w_resp || w_timeout;
    ifu_respValid = w_done && !r_gnt;
    lsu_respValid = w_done && r_gnt;
    ifu_rdata     = (w_resp && !r_gnt) ? mem_rdata : '0;
    lsu_rdata     = (w_resp && r_gnt) ? mem_rdata : '0;
    ifu_err       = w_timeout && !r_gnt;
    lsu_err       = w_timeout && r_gnt;
    mem_reqValid  = (r_state == S_ISSUE);
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_gnt       <= 1'b0;
      r_last_lsu  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_size  <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_gnt <= w_pick_lsu;
        if (w_pick_lsu) begin
          r_mem_addr  <= lsu_addr;
          r_mem_size  <= lsu_size;
          r_mem_wen   <= lsu_wen;
          r_mem_wdata <= lsu_wdata;
          r_mem_wmask <= lsu_wmask;
        end else begin
          r_mem_addr  <= ifu_addr;
          r_mem_size  <= 2'd2;
          r_mem_wen   <= 1'b0;
          r_mem_wdata <= '0;
          r_mem_wmask <= '0;
        end
      end
      if (w_done) r_last_lsu <= r_gnt;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_size  = r_mem_size;
  assign mem_wen   = r_mem_wen;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_ysyx_25030093_bus_arbiter.sv
// Directed bench for ysyx_25030093_bus_arbiter: a fixed-priority instance with a latency-programmable
// memory, plus a round-robin instance with a one-cycle memory and both requesters held high.
module tb_ysyx_25030093_bus_arbiter;
  logic        clock;
  logic        reset;
  logic        ifu_reqValid, lsu_reqValid, lsu_wen, mem_respValid;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [1:0]  lsu_size;
  logic [3:0]  lsu_wmask;
  logic        ifu_respValid, lsu_respValid, ifu_err, lsu_err, mem_reqValid, mem_wen;
  logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wmask;

  logic        rr_en;
  logic [31:0] rr_ifu_addr, rr_lsu_addr, rr_zero32, rr_mem_rdata;
  logic [1:0]  rr_lsu_size;
  logic [3:0]  rr_zero4;
  logic        rr_ifu_respValid, rr_lsu_respValid, rr_ifu_err, rr_lsu_err, rr_mem_reqValid, rr_mem_wen;
  logic [31:0] rr_ifu_rdata, rr_lsu_rdata, rr_mem_addr, rr_mem_wdata;
  logic [1:0]  rr_mem_size;
  logic [3:0]  rr_mem_wmask;
  logic        rr_d1 = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 3;
  logic [31:0] mem_data = 32'h0;
  bit mem_silent = 1'b0;

  int n_req = 0, n_ifu = 0, n_lsu = 0, last_req_cyc = 0, last_ifu_cyc = 0;
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [31:0] rr_q[$];
  int rr_resp = 0, rr_bad = 0;

  ysyx_25030093_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(1), .TIMEOUT_CYCLES(8)) u_dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr), .ifu_respValid(ifu_respValid),
    .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_respValid(lsu_respValid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_reqValid(mem_reqValid), .mem_addr(mem_addr), .mem_size(mem_size), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_respValid(mem_respValid),
    .mem_rdata(mem_rdata)
  );

  ysyx_25030093_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(0), .TIMEOUT_CYCLES(8)) u_rr (
    .clock(clock), .reset(reset),
    .ifu_reqValid(rr_en), .ifu_addr(rr_ifu_addr), .ifu_respValid(rr_ifu_respValid),
    .ifu_rdata(rr_ifu_rdata), .ifu_err(rr_ifu_err),
    .lsu_reqValid(rr_en), .lsu_addr(rr_lsu_addr), .lsu_size(rr_lsu_size), .lsu_wen(1'b0),
    .lsu_wdata(rr_zero32), .lsu_wmask(rr_zero4), .lsu_respValid(rr_lsu_respValid),
    .lsu_rdata(rr_lsu_rdata), .lsu_err(rr_lsu_err),
    .mem_reqValid(rr_mem_reqValid), .mem_addr(rr_mem_addr), .mem_size(rr_mem_size),
    .mem_wen(rr_mem_wen), .mem_wdata(rr_mem_wdata), .mem_wmask(rr_mem_wmask),
    .mem_respValid(rr_d1), .mem_rdata(rr_mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) rr_d1 <= rr_mem_reqValid;

  // Memory model for u_dut: answers mem_lat cycles after the request pulse.
  initial begin
    logic [31:0] d;
    int lat;
    mem_respValid = 1'b0;
    mem_rdata     = 32'h0;
    forever begin
      @(negedge clock);
      if (mem_reqValid && !mem_silent) begin
        d = mem_data;
        lat = mem_lat;
        repeat (lat) @(posedge clock);
        #1 mem_respValid = 1'b1; mem_rdata = d;
        @(posedge clock);
        #1 mem_respValid = 1'b0; mem_rdata = 32'h0;
      end
    end
  end

  always @(negedge clock) begin
    if (mem_reqValid) begin
      n_req++; last_req_cyc = cyc;
      req_addr_q.push_back(mem_addr); req_cyc_q.push_back(cyc);
    end
    if (ifu_respValid) begin n_ifu++; last_ifu_cyc = cyc; end
    if (lsu_respValid) n_lsu++;
    if (rr_mem_reqValid) begin
      rr_q.push_back(rr_mem_addr);
      if (rr_mem_wen || rr_mem_size != 2'd2 || rr_mem_wmask != 4'h0 || rr_mem_wdata != 32'h0) rr_bad++;
    end
    if (rr_ifu_respValid || rr_lsu_respValid) begin
      rr_resp++;
      if (rr_ifu_err || rr_lsu_err) rr_bad++;
      if (rr_ifu_respValid && rr_ifu_rdata != 32'hCAFE0000) rr_bad++;
      if (rr_lsu_respValid && rr_lsu_rdata != 32'hCAFE0000) rr_bad++;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (mem_reqValid !== 1'b0) begin errors++; $display("FAIL reset_mem_reqValid got %0b want 0", mem_reqValid); end
    checks++; if ({ifu_respValid, lsu_respValid} !== 2'b00) begin errors++; $display("FAIL reset_respValid got %b want 00", {ifu_respValid, lsu_respValid}); end
    checks++; if ({mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask} !== '0) begin errors++; $display("FAIL reset_mem_fields addr %h size %0d wen %0b wdata %h wmask %h want all 0", mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask); end
    checks++; if ({ifu_err, lsu_err, ifu_rdata, lsu_rdata} !== '0) begin errors++; $display("FAIL reset_resp_fields err %b%b ifu_rdata %h lsu_rdata %h want 0", ifu_err, lsu_err, ifu_rdata, lsu_rdata); end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_ifu_only();
    int n0_req = n_req, n0_ifu = n_ifu, n0_lsu = n_lsu;
    bit seen = 1'b0;
    @(posedge clock); #1;
    mem_lat = 3; mem_data = 32'h00000413; ifu_addr = 32'h80000000; ifu_reqValid = 1'b1;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clock);
      if (ifu_respValid) begin
        seen = 1'b1;
        checks++; if (ifu_rdata !== 32'h00000413) begin errors++; $display("FAIL ifu_rdata got %h want 00000413", ifu_rdata); end
        checks++; if (lsu_respValid !== 1'b0) begin errors++; $display("FAIL ifu_lsu_respValid got %0b want 0", lsu_respValid); end
        checks++; if ({mem_addr, mem_size, mem_wen, ifu_err} !== {32'h80000000, 2'd2, 1'b0, 1'b0}) begin errors++; $display("FAIL ifu_mem_fields addr %h size %0d wen %0b err %0b want 80000000 2 0 0", mem_addr, mem_size, mem_wen, ifu_err); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL ifu_timeout got no ifu_respValid want one within 30 cycles"); end
    @(posedge clock); #1 ifu_reqValid = 1'b0;
    @(negedge clock);
    checks++; if ({ifu_respValid, ifu_rdata} !== 33'h0) begin errors++; $display("FAIL ifu_pulse_width respValid %0b rdata %h want 0 0", ifu_respValid, ifu_rdata); end
    repeat (4) @(negedge clock);
    checks++; if (n_ifu - n0_ifu != 1 || n_req - n0_req != 1 || n_lsu != n0_lsu) begin errors++; $display("FAIL ifu_counts ifu %0d req %0d lsu %0d want 1 1 0", n_ifu - n0_ifu, n_req - n0_req, n_lsu - n0_lsu); end
    checks++; if (last_ifu_cyc - last_req_cyc != 3) begin errors++; $display("FAIL ifu_latency got %0d want 3", last_ifu_cyc - last_req_cyc); end
  endtask

  task automatic test_simultaneous();
    int qb = req_addr_q.size();
    int lcyc = 0, icyc = 0;
    bit ld = 1'b0, id = 1'b0, l, i;
    @(posedge clock); #1;
    mem_lat = 2; mem_data = 32'h12345678;
    ifu_addr = 32'h80000000; ifu_reqValid = 1'b1;
    lsu_addr = 32'h80001000; lsu_size = 2'd2; lsu_wen = 1'b0; lsu_reqValid = 1'b1;
    for (int k = 0; k < 80 && !(ld && id); k++) begin
      @(negedge clock);
      l = lsu_respValid; i = ifu_respValid;
      if (l) begin
        ld = 1'b1; lcyc = cyc;
        checks++; if (lsu_rdata !== 32'h12345678 || ifu_respValid !== 1'b0) begin errors++; $display("FAIL sim_lsu_resp rdata %h ifu_respValid %0b want 12345678 0", lsu_rdata, ifu_respValid); end
      end
      if (i) begin id = 1'b1; icyc = cyc; end
      @(posedge clock); #1;
      if (l) lsu_reqValid = 1'b0;
      if (i) ifu_reqValid = 1'b0;
    end
    repeat (3) @(negedge clock);
    checks++; if (!(ld && id) || lcyc >= icyc) begin errors++; $display("FAIL sim_order lsu_done %0b@%0d ifu_done %0b@%0d want lsu first", ld, lcyc, id, icyc); end
    checks++; if (req_addr_q.size() - qb != 2) begin errors++; $display("FAIL sim_req_count got %0d want 2", req_addr_q.size() - qb); end
    else begin
      checks++; if (req_addr_q[qb] !== 32'h80001000 || req_addr_q[qb+1] !== 32'h80000000) begin errors++; $display("FAIL sim_grant_addr got %h,%h want 80001000,80000000", req_addr_q[qb], req_addr_q[qb+1]); end
      checks++; if (req_cyc_q[qb+1] != lcyc + 2) begin errors++; $display("FAIL sim_ifu_issue got cycle %0d want %0d", req_cyc_q[qb+1], lcyc + 2); end
    end
  endtask

  task automatic test_store();
    int n0_lsu = n_lsu;
    bit seen = 1'b0;
    @(posedge clock); #1;
    mem_lat = 2; mem_data = 32'h0;
    lsu_addr = 32'h80002003; lsu_size = 2'd0; lsu_wen = 1'b1; lsu_wdata = 32'hAB000000; lsu_wmask = 4'b1000;
    lsu_reqValid = 1'b1;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clock);
      if (lsu_respValid) begin
        seen = 1'b1;
        checks++; if ({mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask} !== {32'h80002003, 2'd0, 1'b1, 32'hAB000000, 4'b1000}) begin errors++; $display("FAIL store_fields addr %h size %0d wen %0b wdata %h wmask %b want 80002003 0 1 ab000000 1000", mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask); end
        checks++; if (ifu_respValid !== 1'b0 || lsu_err !== 1'b0) begin errors++; $display("FAIL store_side ifu_respValid %0b lsu_err %0b want 0 0", ifu_respValid, lsu_err); end
      end
    end
    @(posedge clock); #1 lsu_reqValid = 1'b0; lsu_wen = 1'b0; lsu_wmask = 4'h0;
    repeat (4) @(negedge clock);
    checks++; if (!seen || n_lsu - n0_lsu != 1) begin errors++; $display("FAIL store_pulses got %0d want 1", n_lsu - n0_lsu); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_a [4];
    int rb = rr_q.size();
    int r0 = rr_resp;
    exp_a[0] = 32'h2000; exp_a[1] = 32'h1000; exp_a[2] = 32'h2000; exp_a[3] = 32'h1000;
    @(posedge clock); #1 rr_en = 1'b1;
    for (int k = 0; k < 100 && rr_q.size() - rb < 4; k++) @(negedge clock);
    @(posedge clock); #1 rr_en = 1'b0;
    repeat (6) @(negedge clock);
    checks++; if (rr_q.size() - rb != 4) begin errors++; $display("FAIL rr_grant_count got %0d want 4", rr_q.size() - rb); end
    else for (int j = 0; j < 4; j++) begin
      checks++; if (rr_q[rb+j] !== exp_a[j]) begin errors++; $display("FAIL rr_grant_%0d got %h want %h", j, rr_q[rb+j], exp_a[j]); end
    end
    checks++; if (rr_resp - r0 != 4 || rr_bad != 0) begin errors++; $display("FAIL rr_resp got %0d responses %0d bad want 4 0", rr_resp - r0, rr_bad); end
  endtask

  task automatic test_reset_mid();
    int n0_req = n_req, n0_ifu = n_ifu, n0_lsu = n_lsu;
    bit seen = 1'b0;
    @(posedge clock); #1;
    mem_lat = 5; mem_data = 32'hDEAD0001; ifu_addr = 32'h80000100; ifu_reqValid = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin @(negedge clock); if (mem_reqValid) seen = 1'b1; end
    @(posedge clock); #1 ifu_reqValid = 1'b0; reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    repeat (8) @(negedge clock);
    checks++; if (!seen || n_ifu != n0_ifu || n_lsu != n0_lsu || n_req - n0_req != 1) begin errors++; $display("FAIL rst_mid_ignored issued %0b ifu %0d lsu %0d req %0d want 1 0 0 1", seen, n_ifu - n0_ifu, n_lsu - n0_lsu, n_req - n0_req); end
    seen = 1'b0;
    @(posedge clock); #1;
    mem_lat = 2; mem_data = 32'h00000055; ifu_addr = 32'h80000200; ifu_reqValid = 1'b1;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clock);
      if (ifu_respValid) begin
        seen = 1'b1;
        checks++; if (ifu_rdata !== 32'h00000055 || mem_addr !== 32'h80000200) begin errors++; $display("FAIL rst_mid_next rdata %h addr %h want 00000055 80000200", ifu_rdata, mem_addr); end
      end
    end
    @(posedge clock); #1 ifu_reqValid = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (!seen || n_ifu - n0_ifu != 1) begin errors++; $display("FAIL rst_mid_next_count got %0d want 1", n_ifu - n0_ifu); end
  endtask

  task automatic test_timeout();
    int icyc = 0;
    bit issued = 1'b0, got = 1'b0;
    @(posedge clock); #1;
    mem_silent = 1'b1; lsu_addr = 32'h80003000; lsu_size = 2'd2; lsu_wen = 1'b0; lsu_reqValid = 1'b1;
    for (int k = 0; k < 20 && !issued; k++) begin @(negedge clock); if (mem_reqValid) begin issued = 1'b1; icyc = cyc; end end
`ifdef YSYX_ARB_TIMEOUT_EN
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      if (lsu_respValid) begin
        got = 1'b1;
        checks++; if (lsu_err !== 1'b1 || lsu_rdata !== 32'h0 || ifu_respValid !== 1'b0) begin errors++; $display("FAIL tmo_resp err %0b rdata %h ifu_respValid %0b want 1 0 0", lsu_err, lsu_rdata, ifu_respValid); end
        checks++; if (cyc - icyc != 8) begin errors++; $display("FAIL tmo_latency got %0d want 8", cyc - icyc); end
      end
    end
    checks++; if (!issued || !got) begin errors++; $display("FAIL tmo_seen issued %0b resp %0b want 1 1", issued, got); end
`else
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (lsu_respValid || ifu_respValid || lsu_err || ifu_err) got = 1'b1;
    end
    checks++; if (!issued || got) begin errors++; $display("FAIL tmo_still_waiting issued %0b resp %0b want 1 0", issued, got); end
`endif
    @(posedge clock); #1 lsu_reqValid = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0; mem_silent = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ifu_reqValid = 1'b0; ifu_addr = 32'h0;
    lsu_reqValid = 1'b0; lsu_addr = 32'h0; lsu_size = 2'd0; lsu_wen = 1'b0;
    lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    rr_en = 1'b0; rr_ifu_addr = 32'h1000; rr_lsu_addr = 32'h2000; rr_lsu_size = 2'd2;
    rr_zero32 = 32'h0; rr_zero4 = 4'h0; rr_mem_rdata = 32'hCAFE0000;
    test_reset();
    test_ifu_only();
    test_simultaneous();
    test_store();
    test_round_robin();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
